tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 143 ++++++++++++++
 tb/tb_tick_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: round-robin arbiter that serialises one-cycle event ticks
// from N_REQ requesters onto a single shared tick channel. Consecutive ticks
// are separated by at least GAP low cycles, so a downstream pulse stretcher
// never merges two of them.
//
// Ports:
//   clk        single clock, all state updates on posedge
//   reset      asynchronous active-high reset
//   req        one-cycle event per requester (bit i = one event from i)
//   ovf_clr    synchronous clear of ovf_count (beats same-cycle increments)
//   tick_out   registered one-cycle tick, high only in ISSUE
//   tick_id    registered index of the requester being issued, 0 otherwise
//   pending    registered per-requester pending-event flags
//   ovf_count  registered saturating count of dropped events
module tick_scheduler #(
    parameter int N_REQ = 4,
    parameter int GAP   = 3,
    parameter int IDW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             ovf_clr,
    output logic             tick_out,
    output logic [IDW-1:0]   tick_id,
    output logic [N_REQ-1:0] pending,
    output logic [7:0]       ovf_count
);

    localparam int HCW = (GAP + 1 > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [7:0]       ovf_count_q, ovf_count_d;
    logic             tick_out_q, tick_out_d;
    logic [IDW-1:0]   tick_id_q, tick_id_d;

    logic             arb;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic             grant;
    logic [N_REQ-1:0] grant_mask;
    logic [N_REQ-1:0] drops;
    logic [8:0]       ovf_sum;

    // Round-robin winner: first pending bit at or above last_grant+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && pending_q[(int'(last_grant_q) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(last_grant_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        // Arbitration happens in IDLE or on the final HOLD cycle, so a new
        // ISSUE can follow the last HOLD cycle directly (period GAP+1).
        arb   = (state_q == IDLE) ||
                (state_q == HOLD && hold_cnt_q == HCW'(GAP));
        grant = arb && win_found;

        grant_mask = '0;
        if (grant) grant_mask[win_idx] = 1'b1;

        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_grant_d = grant ? win_idx : last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (grant) state_d = ISSUE;
            end
            ISSUE: begin
                state_d    = HOLD;
                hold_cnt_d = HCW'(1);
            end
            HOLD: begin
                if (hold_cnt_q == HCW'(GAP)) begin
                    state_d    = grant ? ISSUE : IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

        tick_out_d = grant;
        tick_id_d  = grant ? win_idx : '0;

        // A request landing on the edge that clears its bit re-arms it (set
        // wins); any other request against an already set bit is a drop.
        drops     = req & pending_q & ~grant_mask;
        pending_d = (pending_q & ~grant_mask) | req;

        ovf_sum = {1'b0, ovf_count_q};
        for (int i = 0; i < N_REQ; i++) begin
            ovf_sum = ovf_sum + 9'(drops[i]);
        end
        if (ovf_clr)             ovf_count_d = '0;
        else if (ovf_sum > 9'd255) ovf_count_d = 8'd255;
        else                       ovf_count_d = ovf_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            last_grant_q <= IDW'(N_REQ - 1);
            pending_q    <= '0;
            ovf_count_q  <= '0;
            tick_out_q   <= 1'b0;
            tick_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            ovf_count_q  <= ovf_count_d;
            tick_out_q   <= tick_out_d;
            tick_id_q    <= tick_id_d;
        end
    end

    assign tick_out  = tick_out_q;
    assign tick_id   = tick_id_q;
    assign pending   = pending_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    localparam int N   = 4;
    localparam int GAP = 3;
    localparam int IDW = 2;
    localparam int VW  = 1 + IDW + N + 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic           ovf_clr = 1'b0;
    logic           tick_out;
    logic [IDW-1:0] tick_id;
    logic [N-1:0]   pending;
    logic [7:0]     ovf_count;

    int total = 0;
    int bad   = 0;

    tick_scheduler #(.N_REQ(N), .GAP(GAP), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .ovf_clr(ovf_clr),
        .tick_out(tick_out), .tick_id(tick_id), .pending(pending),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Reference model: a tick may be issued in cycle c+1 when something is
    // pending in cycle c and at least GAP cycles have passed since the last
    // tick. Round-robin pointer is the index last granted.
    logic [N-1:0] m_pend;
    int m_last, m_last_tick, m_cyc, m_ovf, m_id;
    logic m_tick;

    task automatic model_reset();
        m_pend = '0; m_last = N - 1; m_last_tick = -1000;
        m_ovf = 0; m_tick = 1'b0; m_id = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic c);
        int g;
        logic [N-1:0] gm;
        logic [N-1:0] dr;
        if (reset) begin
            model_reset();
            m_cyc++;
            return;
        end
        g = -1;
        if (m_pend != 0 && m_cyc - m_last_tick >= GAP)
            for (int k = 1; k <= N; k++)
                if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
        gm = '0;
        if (g >= 0) gm[g] = 1'b1;
        dr = r & m_pend & ~gm;
        m_pend = (m_pend & ~gm) | r;
        if (c) m_ovf = 0;
        else m_ovf = (m_ovf + $countones(dr) > 255) ? 255 : m_ovf + $countones(dr);
        m_cyc++;
        if (g >= 0) begin
            m_tick = 1'b1; m_id = g; m_last = g; m_last_tick = m_cyc;
        end else begin
            m_tick = 1'b0; m_id = 0;
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        return {m_tick, IDW'(m_id), m_pend, 8'(m_ovf)};
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic c);
        req = r;
        ovf_clr = c;
        @(posedge clk);
        model_edge(r, c);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) drive('0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++;
        if ({tick_out, tick_id, pending, ovf_count} !== '0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=0", {tick_out, tick_id, pending, ovf_count});
        end
        model_reset();
        m_cyc = 0;
        drive(4'b1111, 1'b0);
        total++;
        if ({tick_out, tick_id, pending, ovf_count} !== '0) begin
            bad++;
            $display("FAIL reset_held got=%h exp=0", {tick_out, tick_id, pending, ovf_count});
        end
        reset = 1'b0;
    endtask

    task automatic test_burst();
        drive(4'b1111, 1'b0);
        for (int o = 2; o <= 16; o++) begin
            drive('0, 1'b0);
            total++;
            if ({tick_out, tick_id, pending, ovf_count} !== model_vec()) begin
                bad++;
                $display("FAIL burst_model o=%0d got=%h exp=%h", o, {tick_out, tick_id, pending, ovf_count}, model_vec());
            end
            if ((o - 2) % 4 == 0) begin
                total++;
                if (tick_out !== 1'b1 || tick_id !== IDW'((o - 2) / 4)) begin
                    bad++;
                    $display("FAIL burst_tick o=%0d got tick=%b id=%0d exp tick=1 id=%0d", o, tick_out, tick_id, (o - 2) / 4);
                end
            end else if (tick_out !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL burst_gap o=%0d got tick=%b exp tick=0", o, tick_out);
            end
        end
    endtask

    task automatic test_single();
        drain();
        drive(4'b0001, 1'b0);
        total++;
        if (pending !== 4'b0001 || tick_out !== 1'b0) begin
            bad++;
            $display("FAIL single_pend got pend=%b tick=%b exp pend=0001 tick=0", pending, tick_out);
        end
        drive('0, 1'b0);
        total++;
        if (tick_out !== 1'b1 || tick_id !== 2'd0 || pending !== 4'b0000) begin
            bad++;
            $display("FAIL single_tick got tick=%b id=%0d pend=%b exp tick=1 id=0 pend=0000", tick_out, tick_id, pending);
        end
        drive('0, 1'b0);
        total++;
        if (tick_out !== 1'b0 || tick_id !== 2'd0) begin
            bad++;
            $display("FAIL single_after got tick=%b id=%0d exp tick=0 id=0", tick_out, tick_id);
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] ovf0;
        drain();
        ovf0 = ovf_count;
        drive(4'b0010, 1'b0);
        drive(4'b0010, 1'b0);  // request on the edge that grants requester 1
        for (int o = 2; o <= 8; o++) begin
            if (o > 2) drive('0, 1'b0);
            total++;
            if ({tick_out, tick_id, pending, ovf_count} !== model_vec()) begin
                bad++;
                $display("FAIL setwins_model o=%0d got=%h exp=%h", o, {tick_out, tick_id, pending, ovf_count}, model_vec());
            end
            total++;
            if (tick_out !== (o == 2 || o == 6) || (tick_out && tick_id !== 2'd1) || ovf_count !== ovf0) begin
                bad++;
                $display("FAIL setwins_tick o=%0d got tick=%b id=%0d ovf=%0d exp tick=%b id=1 ovf=%0d", o, tick_out, tick_id, ovf_count, (o == 2 || o == 6), ovf0);
            end
        end
    endtask

    task automatic test_fairness();
        int ids[$];
        drain();
        for (int i = 0; i < 40; i++) begin
            drive((i % 4 == 0) ? 4'b0101 : 4'b0000, 1'b0);
            total++;
            if ({tick_out, tick_id, pending, ovf_count} !== model_vec()) begin
                bad++;
                $display("FAIL fair_model i=%0d got=%h exp=%h", i, {tick_out, tick_id, pending, ovf_count}, model_vec());
            end
            if (tick_out) ids.push_back(int'(tick_id));
        end
        total++;
        if (ids.size() < 8) begin
            bad++;
            $display("FAIL fair_count got=%0d exp>=8", ids.size());
        end
        for (int k = 1; k < ids.size(); k++) begin
            total++;
            if (!(ids[k] == 0 || ids[k] == 2) || ids[k] == ids[k-1]) begin
                bad++;
                $display("FAIL fair_alt k=%0d got=%0d prev=%0d exp alternating 0/2", k, ids[k], ids[k-1]);
            end
        end
    endtask

    task automatic test_overflow();
        drain();
        drive('0, 1'b1);
        drive(4'b0001, 1'b0);
        drive(4'b0010, 1'b0);
        drive(4'b0010, 1'b0);  // requester 0 in ISSUE, 1 still pending
        total++;
        if (ovf_count !== 8'd1) begin
            bad++;
            $display("FAIL ovf_one got=%0d exp=1", ovf_count);
        end
        for (int i = 0; i < 360; i++) begin
            drive(4'b0010, 1'b0);
            total++;
            if ({tick_out, tick_id, pending, ovf_count} !== model_vec()) begin
                bad++;
                $display("FAIL ovf_model i=%0d got=%h exp=%h", i, {tick_out, tick_id, pending, ovf_count}, model_vec());
            end
        end
        total++;
        if (ovf_count !== 8'd255) begin
            bad++;
            $display("FAIL ovf_sat got=%0d exp=255", ovf_count);
        end
        drive(4'b0010, 1'b1);
        total++;
        if (ovf_count !== 8'd0) begin
            bad++;
            $display("FAIL ovf_clr got=%0d exp=0", ovf_count);
        end
    endtask

    task automatic test_reset_mid();
        drain();
        drive(4'b0001, 1'b0);
        drive('0, 1'b0);
        drive(4'b0101, 1'b0);
        total++;
        if (pending !== 4'b0101) begin
            bad++;
            $display("FAIL rstmid_setup got pend=%b exp=0101", pending);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total++;
        if ({tick_out, tick_id, pending, ovf_count} !== '0) begin
            bad++;
            $display("FAIL rstmid_async got=%h exp=0", {tick_out, tick_id, pending, ovf_count});
        end
        drive('0, 1'b0);
        reset = 1'b0;
        drive(4'b0100, 1'b0);
        drive('0, 1'b0);
        total++;
        if (tick_out !== 1'b1 || tick_id !== 2'd2 || ovf_count !== 8'd0) begin
            bad++;
            $display("FAIL rstmid_tick got tick=%b id=%0d ovf=%0d exp tick=1 id=2 ovf=0", tick_out, tick_id, ovf_count);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 5) == 0);
            drive(r, $urandom_range(0, 49) == 0);
            total++;
            if ({tick_out, tick_id, pending, ovf_count} !== model_vec()) begin
                bad++;
                $display("FAIL random i=%0d got=%h exp=%h", i, {tick_out, tick_id, pending, ovf_count}, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        m_cyc = 0;
        test_reset();
        test_burst();
        test_single();
        test_set_wins();
        test_fairness();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
